// File: rtl/roundrobin_dispatch.sv
// roundrobin_dispatch: round-robin distribution of one valid/ready stream over N output holding slots
module roundrobin_dispatch #(
    parameter int ARB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pause_i,
    input  logic                            in_vld_i,
    output logic                            in_rdy_o,
    input  logic [DATA_WIDTH-1:0]           in_data_i,
    output logic [ARB_WIDTH-1:0]            out_vld_o,
    input  logic [ARB_WIDTH-1:0]            out_rdy_i,
    output logic [ARB_WIDTH*DATA_WIDTH-1:0] out_data_o,
    output logic [ARB_WIDTH-1:0]            sel_o
);
    localparam int W  = ARB_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic [W-1:0]    ptr_q, ptr_d, vld_q, vld_d, free;
    logic [W*DW-1:0] data_q, data_d;
    logic [2*W-1:0]  dbl, grant;
    logic            accept;

    // Pick the first free slot at or after ptr, wrapping circularly; advance ptr past it on accept
    always_comb begin
        free     = ~vld_q | out_rdy_i;
        dbl      = {free, free};
        grant    = dbl & ~(dbl - {{W{1'b0}}, ptr_q});
        sel_o    = pause_i ? '0 : grant[W-1:0] | grant[2*W-1:W];
        in_rdy_o = |sel_o;
        accept   = in_vld_i & in_rdy_o;
        ptr_d    = accept ? W'({sel_o, sel_o} >> (W - 1)) : ptr_q;
    end

    // Load the chosen slot; a handshaken slot that is not reloaded goes empty, data holds
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        for (int i = 0; i < W; i++) begin
            vld_d[i]               = (accept & sel_o[i]) | (vld_q[i] & ~out_rdy_i[i]);
            data_d[i*DW +: DW]     = (accept & sel_o[i]) ? in_data_i : data_q[i*DW +: DW];
        end
    end

    // State registers; reset drops every held beat and points back at port 0
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
            ptr_q  <= W'(1);
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            ptr_q  <= ptr_d;
        end
    end

    assign out_vld_o  = vld_q;
    assign out_data_o = data_q;
endmodule

// File: tb/tb_roundrobin_dispatch.sv
// tb_roundrobin_dispatch: directed scenarios and randomized scoreboard run against an index-based reference model
module tb_roundrobin_dispatch;
    localparam int W  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pause_i = 1'b0;
    logic            in_vld_i = 1'b0;
    logic            in_rdy_o;
    logic [DW-1:0]   in_data_i = '0;
    logic [W-1:0]    out_vld_o;
    logic [W-1:0]    out_rdy_i = '0;
    logic [W*DW-1:0] out_data_o;
    logic [W-1:0]    sel_o;

    int checks = 0;
    int errors = 0;

    bit            m_vld[W];
    logic [DW-1:0] m_data[W];
    int            m_ptr;

    roundrobin_dispatch #(.ARB_WIDTH(W), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .pause_i(pause_i), .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o),
        .in_data_i(in_data_i), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
        .out_data_o(out_data_o), .sel_o(sel_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] exp_sel();
        if (pause_i) return '0;
        for (int k = 0; k < W; k++) begin
            int i;
            i = (m_ptr + k) % W;
            if (!m_vld[i] || out_rdy_i[i]) return W'(1) << i;
        end
        return '0;
    endfunction

    function automatic logic [W-1:0] exp_vld();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = m_vld[i];
        return v;
    endfunction

    function automatic logic [W*DW-1:0] exp_data();
        logic [W*DW-1:0] d;
        for (int i = 0; i < W; i++) d[i*DW +: DW] = m_data[i];
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_vld[i]  = 1'b0;
            m_data[i] = '0;
        end
        m_ptr = 0;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [W-1:0] r, input logic p);
        @(negedge clk);
        in_vld_i  = v;
        in_data_i = d;
        out_rdy_i = r;
        pause_i   = p;
        #1;
    endtask

    task automatic advance();
        logic [W-1:0] s;
        bit acc;
        s   = exp_sel();
        acc = in_vld_i && (s != 0);
        for (int i = 0; i < W; i++) begin
            if (acc && s[i]) begin
                m_vld[i]  = 1'b1;
                m_data[i] = in_data_i;
                m_ptr     = (i + 1) % W;
            end else if (out_rdy_i[i]) begin
                m_vld[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_vld_i  = 1'b0;
        pause_i   = 1'b0;
        out_rdy_i = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (out_vld_o !== '0 || out_data_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs vld=%b data=%h expected vld=0 data=0", out_vld_o, out_data_o);
        end
        checks++;
        if (sel_o !== 4'b0001 || in_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ptr sel=%b rdy=%b expected sel=0001 rdy=1", sel_o, in_rdy_o);
        end
    endtask

    task automatic run_order(input string name, input logic [W-1:0] rdy, input int ord[8]);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            logic [DW-1:0] d;
            d = $urandom;
            drive(1'b1, d, rdy, 1'b0);
            checks++;
            if (sel_o !== (W'(1) << ord[k]) || in_rdy_o !== 1'b1) begin
                errors++;
                $display("FAIL %s_sel beat %0d sel=%b rdy=%b expected port %0d", name, k, sel_o, in_rdy_o, ord[k]);
            end
            advance();
            checks++;
            if (out_vld_o[ord[k]] !== 1'b1 || out_data_o[ord[k]*DW +: DW] !== d || out_vld_o !== exp_vld() || out_data_o !== exp_data()) begin
                errors++;
                $display("FAIL %s_out beat %0d vld=%b data=%h expected vld=%b data=%h", name, k, out_vld_o, out_data_o, exp_vld(), exp_data());
            end
        end
    endtask

    task automatic test_round_robin();
        run_order("rr", 4'hF, '{0, 1, 2, 3, 0, 1, 2, 3});
    endtask

    task automatic test_skip();
        run_order("skip", 4'b1011, '{0, 1, 2, 3, 0, 1, 3, 0});
    endtask

    task automatic test_full_stall();
        logic [W*DW-1:0] old;
        logic [DW-1:0] d;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, $urandom, 4'h0, 1'b0);
            advance();
        end
        checks++;
        if (out_vld_o !== 4'hF || out_data_o !== exp_data()) begin
            errors++;
            $display("FAIL stall_fill vld=%b data=%h expected vld=1111 data=%h", out_vld_o, out_data_o, exp_data());
        end
        drive(1'b1, $urandom, 4'h0, 1'b0);
        checks++;
        if (in_rdy_o !== 1'b0 || sel_o !== 4'b0000) begin
            errors++;
            $display("FAIL stall_full rdy=%b sel=%b expected rdy=0 sel=0000", in_rdy_o, sel_o);
        end
        advance();
        d = $urandom;
        drive(1'b1, d, 4'b0100, 1'b0);
        checks++;
        if (in_rdy_o !== 1'b1 || sel_o !== 4'b0100) begin
            errors++;
            $display("FAIL stall_release rdy=%b sel=%b expected rdy=1 sel=0100", in_rdy_o, sel_o);
        end
        old = out_data_o;
        advance();
        old[2*DW +: DW] = d;
        checks++;
        if (out_vld_o !== 4'hF || out_data_o !== old) begin
            errors++;
            $display("FAIL stall_reload vld=%b data=%h expected vld=1111 data=%h", out_vld_o, out_data_o, old);
        end
    endtask

    task automatic test_pause();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, $urandom, 4'h0, 1'b0);
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, $urandom, 4'hF, 1'b1);
            checks++;
            if (in_rdy_o !== 1'b0 || sel_o !== 4'b0000) begin
                errors++;
                $display("FAIL pause_gate cycle %0d rdy=%b sel=%b expected rdy=0 sel=0000", k, in_rdy_o, sel_o);
            end
            advance();
            checks++;
            if (out_vld_o !== 4'b0000 || out_data_o !== exp_data()) begin
                errors++;
                $display("FAIL pause_drain cycle %0d vld=%b data=%h expected vld=0000 data=%h", k, out_vld_o, out_data_o, exp_data());
            end
        end
        drive(1'b1, 32'hCAFE_0003, 4'hF, 1'b0);
        checks++;
        if (sel_o !== 4'b1000) begin
            errors++;
            $display("FAIL pause_resume sel=%b expected 1000", sel_o);
        end
        advance();
        checks++;
        if (out_vld_o !== 4'b1000 || out_data_o[3*DW +: DW] !== 32'hCAFE_0003) begin
            errors++;
            $display("FAIL pause_resume_out vld=%b data3=%h expected vld=1000 data3=cafe0003", out_vld_o, out_data_o[3*DW +: DW]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, $urandom, 4'h0, 1'b0);
            advance();
        end
        drive(1'b1, $urandom, 4'h0, 1'b0);
        advance();
        @(negedge clk);
        rst = 1'b1;
        in_vld_i = 1'b1;
        in_data_i = 32'h1234_5678;
        @(posedge clk);
        #1;
        checks++;
        if (out_vld_o !== 4'b0000 || out_data_o !== '0) begin
            errors++;
            $display("FAIL midrst_clear vld=%b data=%h expected vld=0000 data=0", out_vld_o, out_data_o);
        end
        rst = 1'b0;
        model_reset();
        drive(1'b1, 32'h0BAD_F00D, 4'hF, 1'b0);
        checks++;
        if (sel_o !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_ptr sel=%b expected 0001", sel_o);
        end
        advance();
        checks++;
        if (out_vld_o !== 4'b0001 || out_data_o[DW-1:0] !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL midrst_first vld=%b data0=%h expected vld=0001 data0=0badf00d", out_vld_o, out_data_o[DW-1:0]);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] q[W][$];
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            logic [W-1:0] s;
            drive(($urandom % 4) != 0, $urandom, W'($urandom), ($urandom % 8) == 0);
            s = exp_sel();
            checks++;
            if (sel_o !== s || in_rdy_o !== (s != 0)) begin
                errors++;
                $display("FAIL rand_sel cycle %0d sel=%b rdy=%b expected sel=%b rdy=%b", n, sel_o, in_rdy_o, s, s != 0);
            end
            for (int i = 0; i < W; i++) begin
                if (out_vld_o[i] && out_rdy_i[i]) begin
                    checks++;
                    if (q[i].size() == 0) begin
                        errors++;
                        $display("FAIL rand_extra cycle %0d port %0d data=%h expected no beat", n, i, out_data_o[i*DW +: DW]);
                    end else if (out_data_o[i*DW +: DW] !== q[i][0]) begin
                        errors++;
                        $display("FAIL rand_order cycle %0d port %0d data=%h expected %h", n, i, out_data_o[i*DW +: DW], q[i][0]);
                        void'(q[i].pop_front());
                    end else begin
                        void'(q[i].pop_front());
                    end
                end
            end
            if (in_vld_i) for (int i = 0; i < W; i++) if (s[i]) q[i].push_back(in_data_i);
            advance();
            checks++;
            if (out_vld_o !== exp_vld() || out_data_o !== exp_data()) begin
                errors++;
                $display("FAIL rand_out cycle %0d vld=%b data=%h expected vld=%b data=%h", n, out_vld_o, out_data_o, exp_vld(), exp_data());
            end
        end
        for (int i = 0; i < W; i++) begin
            checks++;
            if (q[i].size() != int'(out_vld_o[i])) begin
                errors++;
                $display("FAIL rand_lost port %0d outstanding=%0d expected %0d", i, q[i].size(), out_vld_o[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_skip();
        test_full_stall();
        test_pause();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
